uart_tx_feeder: RTL and testbench

- Upstream buffer stage for the UART transmitter.
- Accepts bytes from the system side into a small synchronous FIFO.
- Hands each byte to the TX control FSM as a one-cycle Data_Valid pulse with stable parallel data, paced by the FSM's busy output.
- Absorbs bursts so the system side never waits on frame timing; reports fill level and a sticky overflow.

---
 rtl/uart_tx_feeder_pkg.sv | 14 +
 rtl/uart_tx_feeder_sync_fifo.sv | 82 ++++++++
 rtl/uart_tx_feeder.sv | 110 +++++++++++
 tb/tb_uart_tx_feeder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared types and defaults for the UART TX feeder
package uart_tx_feeder_pkg;

   localparam int DATA_WIDTH_DEFAULT = 8;

   // Handshake FSM encoding towards the TX control FSM
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// rtl/uart_tx_feeder_sync_fifo.sv - circular-buffer FIFO with registered count and sticky overflow
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      wr_en_i,
   input  logic [DATA_WIDTH-1:0]     wr_data_i,
   input  logic                      rd_en_i,
   output logic [DATA_WIDTH-1:0]     rd_data_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  push, pop;

   assign full_o     = (count_q == CNT_FULL);
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign overflow_o = overflow_q;
   assign rd_data_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a write
   assign pop  = rd_en_i && !empty_o;
   assign push = wr_en_i && (!full_o || pop);

   // Next pointer/count/overflow; flush wins over any same-cycle write or pop
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push && !pop) count_d = count_q + CNT_ONE;
         if (pop && !push) count_d = count_q - CNT_ONE;
         if (wr_en_i && !push) overflow_d = 1'b1;
      end
   end

   // Pointer, count and overflow registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage array; contents need no reset since count gates every read
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered Data_Valid feeder for the UART TX control FSM
import uart_tx_feeder_pkg::*;

module uart_tx_feeder #(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
   parameter int DEPTH        = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      wr_en_i,
   input  logic [DATA_WIDTH-1:0]     wr_data_i,
   input  logic                      flush_i,
   input  logic                      tx_busy_i,
   output logic                      tx_valid_o,
   output logic [DATA_WIDTH-1:0]     tx_data_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      overflow_o
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(BUSY_TIMEOUT);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

   state_e                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_empty;
   logic                  pop;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .wr_en_i    (wr_en_i),
      .wr_data_i  (wr_data_i),
      .rd_en_i    (pop),
      .rd_data_o  (fifo_head),
      .full_o     (full_o),
      .empty_o    (fifo_empty),
      .count_o    (count_o),
      .overflow_o (overflow_o)
   );

   assign empty_o = fifo_empty;

   // Only pop when the transmitter is idle, so a frame started elsewhere is never overrun
   assign pop = (state_q == IDLE) && !fifo_empty && !tx_busy_i;

   // State, timeout counter and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Next state: issue, then wait for busy to rise (bounded) and fall
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         IDLE: begin
            if (pop) state_d = ISSUE;
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
            timer_d = TMO_LOAD;
         end
         WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_d = WAIT_DONE;
            end else if (timer_q <= TMO_ONE) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q - TMO_ONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values: valid only while in ISSUE, data latched at the pop
   always_comb begin
      tx_valid_d = (state_d == ISSUE);
      tx_data_d  = pop ? fifo_head : tx_data_q;
   end

   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int BT    = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic          wr;
      logic          fl;
      logic [DW-1:0] data;
      logic [CW-1:0] cnt;
      logic          full;
      logic          empty;
      logic          ovf;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          flush = 1'b0;
   logic          force_busy = 1'b0;
   logic          model_busy = 1'b0;
   logic          model_respond = 1'b1;
   logic          tx_busy;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic          full, empty, overflow;
   logic [CW-1:0] count;

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   logic [DW-1:0] sb[$];
   int            vtimes[$];
   logic          prev_valid = 1'b0;
   vec_t          vecs[14];

   assign tx_busy = force_busy | model_busy;

   uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .flush_i    (flush),
      .tx_busy_i  (tx_busy),
      .tx_valid_o (tx_valid),
      .tx_data_o  (tx_data),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (count),
      .overflow_o (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // monitor / scoreboard
   initial forever begin
      @(negedge clk);
      if (rst_n && tx_valid) begin
         check("tx_valid one cycle wide", {31'd0, prev_valid}, 0);
         check("tx_busy low at tx_valid", {31'd0, tx_busy}, 0);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected tx_valid: data 0x%0h with nothing expected", tx_data);
         end else begin
            logic [DW-1:0] exp;
            exp = sb.pop_front();
            check("tx_data order", {24'd0, tx_data}, {24'd0, exp});
         end
         vtimes.push_back(cyc);
      end
      prev_valid = rst_n && tx_valid;
   end

   // TX control FSM model: busy rises 1 cycle after tx_valid, falls 11 cycles later
   initial forever begin
      logic [DW-1:0] cap;
      @(negedge clk);
      if (rst_n && tx_valid && model_respond) begin
         cap = tx_data;
         @(negedge clk);
         if (rst_n) begin
            model_busy = 1'b1;
            for (int i = 0; i < 11; i++) begin
               @(negedge clk);
               if (!rst_n) break;
               check("tx_data stable in frame", {24'd0, tx_data}, {24'd0, cap});
            end
         end
         model_busy = 1'b0;
      end
   end

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while ((sb.size() != 0 || !empty || tx_busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("drain within bound", {31'd0, (n < limit)}, 1);
      repeat (16) @(negedge clk);
   endtask

   task automatic write_byte(input logic [DW-1:0] d, input bit expect_issue);
      wr_en   = 1'b1;
      wr_data = d;
      if (expect_issue) sb.push_back(d);
   endtask

   initial begin
      int k, peak, n;

      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b1, 1'b0, DW'(8'h80 + i), CW'(i + 1), (i == 7), 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 8'h99, CW'(8), 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, CW'(8), 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 8'h00, CW'(0), 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 8'h44, CW'(0), 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 8'h45, CW'(1), 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 8'h00, CW'(0), 1'b0, 1'b1, 1'b0};

      // reset values
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset tx_valid", {31'd0, tx_valid}, 0);
      check("reset tx_data", {24'd0, tx_data}, 0);
      check("reset count", {28'd0, count}, 0);
      check("reset empty", {31'd0, empty}, 1);
      check("reset full", {31'd0, full}, 0);
      check("reset overflow", {31'd0, overflow}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single byte latency
      vtimes.delete();
      k = cyc;
      write_byte(8'hA5, 1);
      @(negedge clk);
      wr_en = 1'b0;
      check("count after single write", {28'd0, count}, 1);
      wait_drain(100);
      check("single issue count", vtimes.size(), 1);
      if (vtimes.size() >= 1) check("write to tx_valid latency", vtimes[0] - k, 2);
      check("tx_data held after frame", {24'd0, tx_data}, 8'hA5);
      check("count back to 0", {28'd0, count}, 0);

      // burst of three
      vtimes.delete();
      peak = 0;
      for (int i = 0; i < 3; i++) begin
         write_byte(DW'(8'h11 * (i + 1)), 1);
         @(negedge clk);
         if (int'(count) > peak) peak = int'(count);
      end
      wr_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (int'(count) > peak) peak = int'(count);
      end
      check("burst peak count 2..3", {31'd0, (peak >= 2 && peak <= 3)}, 1);
      wait_drain(200);
      check("burst issue count", vtimes.size(), 3);
      if (vtimes.size() == 3) begin
         check("burst spacing 1", {31'd0, (vtimes[1] - vtimes[0] >= 13)}, 1);
         check("burst spacing 2", {31'd0, (vtimes[2] - vtimes[1] >= 13)}, 1);
      end
      check("burst empty at end", {31'd0, empty}, 1);

      // table: fill, overflow, flush priority with busy held high
      force_busy = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 14; r++) begin
         wr_en   = vecs[r].wr;
         flush   = vecs[r].fl;
         wr_data = vecs[r].data;
         @(negedge clk);
         check($sformatf("vec%0d count", r), {28'd0, count}, {28'd0, vecs[r].cnt});
         check($sformatf("vec%0d full", r), {31'd0, full}, {31'd0, vecs[r].full});
         check($sformatf("vec%0d empty", r), {31'd0, empty}, {31'd0, vecs[r].empty});
         check($sformatf("vec%0d overflow", r), {31'd0, overflow}, {31'd0, vecs[r].ovf});
      end
      wr_en = 1'b0;
      flush = 1'b0;

      // full FIFO with simultaneous pop and write
      for (int i = 0; i < DEPTH; i++) begin
         write_byte(DW'(8'hC0 + i), 1);
         @(negedge clk);
      end
      wr_en = 1'b0;
      check("full after DEPTH writes", {31'd0, full}, 1);
      write_byte(8'h7E, 1);
      force_busy = 1'b0;
      @(negedge clk);
      wr_en = 1'b0;
      check("full+pop write count", {28'd0, count}, DEPTH);
      check("full+pop no overflow", {31'd0, overflow}, 0);
      wait_drain(400);
      check("empty after full drain", {31'd0, empty}, 1);

      // lost handshake: busy never rises
      model_respond = 1'b0;
      vtimes.delete();
      write_byte(8'h5A, 1);
      @(negedge clk);
      write_byte(8'h6B, 1);
      @(negedge clk);
      wr_en = 1'b0;
      n = 0;
      while (vtimes.size() < 2 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("timeout second issue seen", {31'd0, (vtimes.size() >= 2)}, 1);
      if (vtimes.size() >= 2) check("timeout issue gap", vtimes[1] - vtimes[0], BT + 2);
      repeat (10) @(negedge clk);
      check("timeout no extra issue", vtimes.size(), 2);
      model_respond = 1'b1;

      // reset while in WAIT_DONE with two bytes queued
      write_byte(8'hD1, 1);
      @(negedge clk);
      write_byte(8'hD2, 0);
      @(negedge clk);
      write_byte(8'hD3, 0);
      @(negedge clk);
      wr_en = 1'b0;
      n = 0;
      while (!model_busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("busy rose before reset", {31'd0, model_busy}, 1);
      repeat (3) @(negedge clk);
      check("queued before reset", {28'd0, count}, 2);
      #2 rst_n = 1'b0;
      #1;
      check("async reset tx_valid", {31'd0, tx_valid}, 0);
      check("async reset tx_data", {24'd0, tx_data}, 0);
      check("async reset count", {28'd0, count}, 0);
      check("async reset empty", {31'd0, empty}, 1);
      check("async reset full", {31'd0, full}, 0);
      check("async reset overflow", {31'd0, overflow}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      vtimes.delete();
      repeat (25) @(negedge clk);
      check("no issue after reset", vtimes.size(), 0);
      write_byte(8'h3C, 1);
      @(negedge clk);
      wr_en = 1'b0;
      wait_drain(100);
      check("issue after reset", vtimes.size(), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
